// File: rtl/perf_pkg.sv
// Shared offsets, widths and event indices for the performance-counter block.
package perf_pkg;

  localparam int unsigned CNT_W_DEF = 64;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_EVT   = 4;

  // Register byte offsets
  localparam logic [ADDR_W-1:0] PERF_CTRL    = 8'h00;
  localparam logic [ADDR_W-1:0] PERF_CYC_LO  = 8'h04;
  localparam logic [ADDR_W-1:0] PERF_CYC_HI  = 8'h08;
  localparam logic [ADDR_W-1:0] PERF_INSN_LO = 8'h0C;
  localparam logic [ADDR_W-1:0] PERF_INSN_HI = 8'h10;
  localparam logic [ADDR_W-1:0] PERF_CTRL_LO = 8'h14;
  localparam logic [ADDR_W-1:0] PERF_CTRL_HI = 8'h18;
  localparam logic [ADDR_W-1:0] PERF_MISP_LO = 8'h1C;
  localparam logic [ADDR_W-1:0] PERF_MISP_HI = 8'h20;

  // Counter slot index
  typedef enum logic [1:0] {
    EVT_CYC  = 2'd0,
    EVT_INSN = 2'd1,
    EVT_CTRL = 2'd2,
    EVT_MISP = 2'd3
  } perf_evt_e;

endpackage

// File: rtl/perf_counter_mmio_if.sv
// Peripheral-bus view of the performance counters (LSU side is master).
interface perf_counter_mmio_if;
  import perf_pkg::*;

  logic              i_cs;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rvalid;
  logic              o_err;

  modport master (
    output i_cs, i_we, i_addr, i_wdata,
    input  o_rdata, o_rvalid, o_err
  );

  modport slave (
    input  i_cs, i_we, i_addr, i_wdata,
    output o_rdata, o_rvalid, o_err
  );

endinterface

// File: rtl/perf_cnt64.sv
// One wide event counter with a HI-word shadow latched on LO reads.
module perf_cnt64
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_inc,
  input  logic              i_snap,
  output logic [DATA_W-1:0] o_lo,
  output logic [DATA_W-1:0] o_hi
);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shadow;

  // Count with priority reset > clear > increment; wraps silently
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Capture the upper bits alongside a LO read so HI reads are coherent
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_shadow <= '0;
    end else if (i_snap) begin
      r_shadow <= DATA_W'(r_cnt[CNT_W-1:32]);
    end
  end

  assign o_lo = r_cnt[31:0];
  assign o_hi = r_shadow;

endmodule

// File: rtl/perf_counter_mmio.sv
// Memory-mapped pipeline performance counters: decode, CTRL and read response.
module perf_counter_mmio
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter bit          BASE_CHK = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_insn_vld,
  input  logic                i_ctrl,
  input  logic                i_mispred,
  perf_counter_mmio_if.slave  bus,
  output logic                o_enable
);

  logic              r_enable;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_err;

  logic              w_mis;
  logic              w_rd;
  logic              w_rd_ok;
  logic              w_ctrl_wr;
  logic              w_clr;
  logic [ADDR_W-1:0] w_word;
  logic [DATA_W-1:0] w_rd_mux;
  logic [NUM_EVT-1:0] w_snap;
  logic [NUM_EVT-1:0] w_inc;
  logic [DATA_W-1:0] w_lo [NUM_EVT];
  logic [DATA_W-1:0] w_hi [NUM_EVT];
  logic              w_unused_wdata;

  // Access qualification; low address bits only matter when checking alignment
  assign w_mis     = BASE_CHK && (bus.i_addr[1:0] != 2'b00);
  assign w_word    = {bus.i_addr[ADDR_W-1:2], 2'b00};
  assign w_rd      = bus.i_cs && !bus.i_we;
  assign w_rd_ok   = w_rd && !w_mis;
  assign w_ctrl_wr = bus.i_cs && bus.i_we && !w_mis && (w_word == PERF_CTRL);
  assign w_clr     = w_ctrl_wr && bus.i_wdata[1];
  assign w_unused_wdata = ^bus.i_wdata[DATA_W-1:2];

  // Event inputs per counter slot
  always_comb begin
    w_inc           = '0;
    w_inc[EVT_CYC]  = 1'b1;
    w_inc[EVT_INSN] = i_insn_vld;
    w_inc[EVT_CTRL] = i_ctrl;
    w_inc[EVT_MISP] = i_mispred;
  end

  // Shadow capture strobes for LO reads
  always_comb begin
    w_snap = '0;
    if (w_rd_ok) begin
      case (w_word)
        PERF_CYC_LO:  w_snap[EVT_CYC]  = 1'b1;
        PERF_INSN_LO: w_snap[EVT_INSN] = 1'b1;
        PERF_CTRL_LO: w_snap[EVT_CTRL] = 1'b1;
        PERF_MISP_LO: w_snap[EVT_MISP] = 1'b1;
        default:      w_snap = '0;
      endcase
    end
  end

  // Read data selection; unmapped offsets read zero
  always_comb begin
    w_rd_mux = '0;
    case (w_word)
      PERF_CTRL:    w_rd_mux = {31'b0, r_enable};
      PERF_CYC_LO:  w_rd_mux = w_lo[EVT_CYC];
      PERF_CYC_HI:  w_rd_mux = w_hi[EVT_CYC];
      PERF_INSN_LO: w_rd_mux = w_lo[EVT_INSN];
      PERF_INSN_HI: w_rd_mux = w_hi[EVT_INSN];
      PERF_CTRL_LO: w_rd_mux = w_lo[EVT_CTRL];
      PERF_CTRL_HI: w_rd_mux = w_hi[EVT_CTRL];
      PERF_MISP_LO: w_rd_mux = w_lo[EVT_MISP];
      PERF_MISP_HI: w_rd_mux = w_hi[EVT_MISP];
      default:      w_rd_mux = '0;
    endcase
  end

  // CTRL.enable; a write takes effect from the following cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_enable <= 1'b1;
    end else if (w_ctrl_wr) begin
      r_enable <= bus.i_wdata[0];
    end
  end

  // One-cycle read response and misalignment strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= bus.i_cs && w_mis;
      r_rdata  <= w_rd_ok ? w_rd_mux : '0;
    end
  end

  perf_cnt64 #(.CNT_W(CNT_W)) u_cnt_cyc (
    .i_clk (i_clk), .i_reset (i_reset), .i_clr (w_clr), .i_en (r_enable),
    .i_inc (w_inc[EVT_CYC]), .i_snap (w_snap[EVT_CYC]),
    .o_lo (w_lo[EVT_CYC]), .o_hi (w_hi[EVT_CYC])
  );

  perf_cnt64 #(.CNT_W(CNT_W)) u_cnt_insn (
    .i_clk (i_clk), .i_reset (i_reset), .i_clr (w_clr), .i_en (r_enable),
    .i_inc (w_inc[EVT_INSN]), .i_snap (w_snap[EVT_INSN]),
    .o_lo (w_lo[EVT_INSN]), .o_hi (w_hi[EVT_INSN])
  );

  perf_cnt64 #(.CNT_W(CNT_W)) u_cnt_ctrl (
    .i_clk (i_clk), .i_reset (i_reset), .i_clr (w_clr), .i_en (r_enable),
    .i_inc (w_inc[EVT_CTRL]), .i_snap (w_snap[EVT_CTRL]),
    .o_lo (w_lo[EVT_CTRL]), .o_hi (w_hi[EVT_CTRL])
  );

  perf_cnt64 #(.CNT_W(CNT_W)) u_cnt_misp (
    .i_clk (i_clk), .i_reset (i_reset), .i_clr (w_clr), .i_en (r_enable),
    .i_inc (w_inc[EVT_MISP]), .i_snap (w_snap[EVT_MISP]),
    .o_lo (w_lo[EVT_MISP]), .o_hi (w_hi[EVT_MISP])
  );

  assign bus.o_rdata  = r_rdata;
  assign bus.o_rvalid = r_rvalid;
  assign bus.o_err    = r_err;
  assign o_enable     = r_enable;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Directed self-checking bench for perf_counter_mmio (BASE_CHK=1).
module tb_perf_counter_mmio;
  import perf_pkg::*;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_insn_vld;
  logic i_ctrl;
  logic i_mispred;
  logic o_enable;

  int n_tests = 0;
  int n_fail  = 0;

  perf_counter_mmio_if bus ();

  perf_counter_mmio #(.CNT_W(64), .BASE_CHK(1'b1)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_insn_vld (i_insn_vld),
    .i_ctrl     (i_ctrl),
    .i_mispred  (i_mispred),
    .bus        (bus),
    .o_enable   (o_enable)
  );

  always #5 i_clk = ~i_clk;

  task automatic drive_idle();
    bus.i_cs    = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_addr  = 8'h00;
    bus.i_wdata = 32'h0;
  endtask

  task automatic drive_rd(input logic [7:0] addr);
    bus.i_cs   = 1'b1;
    bus.i_we   = 1'b0;
    bus.i_addr = addr;
  endtask

  task automatic drive_wr(input logic [7:0] addr, input logic [31:0] data);
    bus.i_cs    = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_addr  = addr;
    bus.i_wdata = data;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_insn_vld = 1'b0; i_ctrl = 1'b0; i_mispred = 1'b0;
    drive_idle();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    n_tests++;
    if (bus.o_rvalid !== 1'b0 || bus.o_rdata !== 32'h0 || bus.o_err !== 1'b0 || o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: rvalid=%b rdata=%h err=%b en=%b, required 0/0/0/1",
               bus.o_rvalid, bus.o_rdata, bus.o_err, o_enable);
    end
  endtask

  task automatic test_cycle_count();
    repeat (100) @(negedge i_clk);
    drive_rd(PERF_CYC_LO);
    @(negedge i_clk);
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'd100 || bus.o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cyc_lo_100: rvalid=%b rdata=%0d err=%b, required 1/100/0",
               bus.o_rvalid, bus.o_rdata, bus.o_err);
    end
    drive_rd(PERF_CYC_HI);
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL cyc_hi_zero: rvalid=%b rdata=%h, required 1/0", bus.o_rvalid, bus.o_rdata);
    end
  endtask

  task automatic test_events();
    for (int i = 0; i < 37; i++) begin
      i_insn_vld = 1'b1;
      i_ctrl     = (i < 10);
      i_mispred  = (i < 3);
      @(negedge i_clk);
    end
    i_insn_vld = 1'b0; i_ctrl = 1'b0; i_mispred = 1'b0;
    drive_rd(PERF_INSN_LO);
    @(negedge i_clk);
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'd37) begin
      n_fail++;
      $display("FAIL insn_37: rvalid=%b rdata=%0d, required 1/37", bus.o_rvalid, bus.o_rdata);
    end
    drive_rd(PERF_CTRL_LO);
    @(negedge i_clk);
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'd10) begin
      n_fail++;
      $display("FAIL ctrl_10: rvalid=%b rdata=%0d, required 1/10", bus.o_rvalid, bus.o_rdata);
    end
    drive_rd(PERF_MISP_LO);
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'd3) begin
      n_fail++;
      $display("FAIL misp_3: rvalid=%b rdata=%0d, required 1/3", bus.o_rvalid, bus.o_rdata);
    end
  endtask

  task automatic test_snapshot();
    force dut.u_cnt_cyc.r_cnt = 64'h0000_0000_FFFF_FFFE;
    @(posedge i_clk);
    #1;
    release dut.u_cnt_cyc.r_cnt;
    @(negedge i_clk);
    @(negedge i_clk);
    drive_rd(PERF_CYC_LO);
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL snap_lo: rvalid=%b rdata=%h, required 1/ffffffff", bus.o_rvalid, bus.o_rdata);
    end
    repeat (5) @(negedge i_clk);
    drive_rd(PERF_CYC_HI);
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL snap_hi_shadow: rdata=%h, required 0", bus.o_rdata);
    end
    drive_rd(PERF_CYC_LO);
    @(negedge i_clk);
    drive_rd(PERF_CYC_HI);
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL snap_hi_wrapped: rdata=%h, required 1", bus.o_rdata);
    end
  endtask

  task automatic test_enable();
    drive_wr(PERF_CTRL, 32'h3);
    @(negedge i_clk);
    drive_wr(PERF_CTRL, 32'h0);
    i_insn_vld = 1'b1; i_ctrl = 1'b1; i_mispred = 1'b1;
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (o_enable !== 1'b0 || bus.o_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_write: en=%b rvalid=%b, required 0/0", o_enable, bus.o_rvalid);
    end
    repeat (20) @(negedge i_clk);
    drive_wr(PERF_CTRL, 32'h1);
    @(negedge i_clk);
    i_insn_vld = 1'b0; i_ctrl = 1'b0; i_mispred = 1'b0;
    n_tests++;
    if (o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_write: en=%b, required 1", o_enable);
    end
    drive_rd(PERF_CYC_LO);
    @(negedge i_clk);
    n_tests++;
    if (bus.o_rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL cyc_held: rdata=%0d, required 1", bus.o_rdata);
    end
    drive_rd(PERF_INSN_LO);
    @(negedge i_clk);
    n_tests++;
    if (bus.o_rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL insn_held: rdata=%0d, required 1", bus.o_rdata);
    end
    drive_rd(PERF_CTRL_LO);
    @(negedge i_clk);
    n_tests++;
    if (bus.o_rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL ctrl_held: rdata=%0d, required 1", bus.o_rdata);
    end
    drive_rd(PERF_MISP_LO);
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL misp_held: rdata=%0d, required 1", bus.o_rdata);
    end
  endtask

  task automatic test_clear();
    i_insn_vld = 1'b1;
    repeat (4) @(negedge i_clk);
    drive_wr(PERF_CTRL, 32'h3);
    @(negedge i_clk);
    i_insn_vld = 1'b0;
    drive_rd(PERF_CYC_LO);
    n_tests++;
    if (o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_enable: en=%b, required 1", o_enable);
    end
    @(negedge i_clk);
    n_tests++;
    if (bus.o_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_cyc: rdata=%0d, required 0", bus.o_rdata);
    end
    drive_rd(PERF_INSN_LO);
    @(negedge i_clk);
    drive_rd(PERF_CTRL);
    n_tests++;
    if (bus.o_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_insn: rdata=%0d, required 0", bus.o_rdata);
    end
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL ctrl_read: rdata=%h, required 1 (clear bit reads 0)", bus.o_rdata);
    end
  endtask

  task automatic test_unmapped_misaligned();
    drive_rd(8'h24);
    @(negedge i_clk);
    drive_rd(8'h05);
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'h0 || bus.o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL unmapped_read: rvalid=%b rdata=%h err=%b, required 1/0/0",
               bus.o_rvalid, bus.o_rdata, bus.o_err);
    end
    @(negedge i_clk);
    drive_wr(8'h01, 32'h0);
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'h0 || bus.o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_read: rvalid=%b rdata=%h err=%b, required 1/0/1",
               bus.o_rvalid, bus.o_rdata, bus.o_err);
    end
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b0 || bus.o_err !== 1'b1 || o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_write: rvalid=%b err=%b en=%b, required 0/1/1",
               bus.o_rvalid, bus.o_err, o_enable);
    end
    @(negedge i_clk);
    n_tests++;
    if (bus.o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: err=%b, required 0", bus.o_err);
    end
  endtask

  task automatic test_reset_inflight();
    drive_wr(PERF_CTRL, 32'h0);
    @(negedge i_clk);
    drive_rd(PERF_CYC_LO);
    @(negedge i_clk);
    i_reset = 1'b1;
    drive_rd(PERF_INSN_LO);
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_read: rvalid=%b en=%b, required 1/0", bus.o_rvalid, o_enable);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b0 || bus.o_rdata !== 32'h0 || bus.o_err !== 1'b0 || o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_drop: rvalid=%b rdata=%h err=%b en=%b, required 0/0/0/1",
               bus.o_rvalid, bus.o_rdata, bus.o_err, o_enable);
    end
    drive_rd(PERF_CYC_LO);
    @(negedge i_clk);
    drive_idle();
    n_tests++;
    if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_cyc: rvalid=%b rdata=%0d, required 1/0", bus.o_rvalid, bus.o_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cycle_count();
    test_events();
    test_snapshot();
    test_enable();
    test_clear();
    test_unmapped_misaligned();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_mmio.md
Name: perf_counter_mmio

Overview:
- Hardware performance-counter unit inside the pipeline, on the LSU peripheral bus.
- Accumulates four events: cycles, retired instructions, control-transfer instructions and branch mispredictions, into 64-bit counters.
- The counters come from the same writeback/EX debug events the pipeline exports (insn_vld, ctrl, mispred).
- Software reads the counters with ordinary loads, so ISA tests can report IPC and misprediction rate on-target rather than only in the bench.

Parameters:
- CNT_W, 64, counter width; must be 33..64; the HI word is zero-extended.
- BASE_CHK, 0, when 1 an access with i_addr[1:0] != 0 returns o_err=1 instead of data.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_insn_vld  in  1  one instruction retired this cycle
- i_ctrl  in  1  a control-transfer instruction resolved this cycle
- i_mispred  in  1  a misprediction resolved this cycle
- i_cs  in  1  bus select; one access per asserted cycle
- i_we  in  1  1=write, 0=read
- i_addr  in  8  byte offset within the block
- i_wdata  in  32  write data
- o_rdata  out  32  read data, valid when o_rvalid=1
- o_rvalid  out  1  read response strobe
- o_err  out  1  misaligned-access strobe, aligned with o_rvalid
- o_enable  out  1  current CTRL.enable, for debug

Behaviour:
- Reset: i_reset=1 sampled on a rising edge clears every counter and shadow register, o_rdata=0, o_rvalid=0, o_err=0, CTRL.enable=1 (o_enable=1). Reset takes priority over all other inputs. A read in flight during reset is dropped, with no o_rvalid.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 enable (R/W); bit1 clear (write-1 pulse, reads 0).
  - 0x04/0x08 CYCLE_LO/HI
  - 0x0C/0x10 INSN_LO/HI
  - 0x14/0x18 CTRL_LO/HI
  - 0x1C/0x20 MISP_LO/HI
  - All other offsets read 0 and ignore writes.
  - Writes to counter offsets are ignored.
- Counting: while enable=1, CYCLE increments every cycle. INSN, CTRL and MISP each increment by 1 in a cycle where their event input is 1. All three events are counted independently; no cross-check is made between mispred and ctrl.
  - An event counted in cycle N is visible to a read issued in cycle N+1.
  - Counters wrap modulo 2^CNT_W with no flag.
- Enable=0: all four counters hold. The enable write takes effect from the next cycle; the write cycle itself still counts under the old value.
- Clear: writing CTRL with bit1=1 zeroes all counters and shadows on that edge. Clear beats a simultaneous increment, so the event in that cycle is lost. Bit0 of the same write still updates enable.
- Read latency: exactly 1 cycle. If i_cs=1 and i_we=0 in cycle N, then o_rvalid=1 with o_rdata in cycle N+1; otherwise o_rvalid=0 and o_rdata=0. Back-to-back reads are fully supported, with no stall and no ready signal.
- Atomic 64-bit snapshot:
  - Reading any *_LO returns counter[31:0] as of the read cycle and, on the same edge, latches counter[CNT_W-1:32] into that counter's shadow.
  - Reading *_HI returns the shadow, not the live value.
  - Reading HI without a prior LO returns the stale shadow (0 after reset/clear).
- A write cycle produces no o_rvalid.
- Misaligned access (BASE_CHK=1, i_addr[1:0]!=0): reads give o_rvalid=1, o_err=1, o_rdata=0; writes are dropped with o_err pulsed 1 cycle later. With BASE_CHK=0, i_addr[1:0] is ignored.

Decomposition:
- perf_pkg:
  - Offset localparams: PERF_CTRL, PERF_CYC_LO … PERF_MISP_HI.
  - CNT_W default.
  - Enum perf_evt_e {EVT_CYC, EVT_INSN, EVT_CTRL, EVT_MISP}, used to index a counter array.
- Sub-module perf_cnt64, instantiated 4×:
  - Inputs: i_clk, i_reset, i_clr, i_en, i_inc, i_snap.
  - Outputs: o_lo[31:0] (live), o_hi (shadow).
  - Priority: reset > clear > increment.
- The top level holds only address decode, CTRL and the response register.

Test Plan:
- Reset, then 100 idle cycles with enable=1, then read CYCLE_LO → o_rvalid next cycle; o_rdata equals the cycle count at the read cycle (100±0 per bench reference model); CYCLE_HI=0.
- Pulse i_insn_vld 37×, i_ctrl 10×, i_mispred 3×, then read INSN_LO/CTRL_LO/MISP_LO back-to-back → 37, 10, 3 on three consecutive o_rvalid cycles.
- Force CYCLE=0x0000_0000_FFFF_FFFE via a bench deposit, read CYCLE_LO at 0xFFFF_FFFF, wait 5 cycles, read CYCLE_HI → LO=0xFFFF_FFFF, HI=0 (shadow, not the live value 1).
- Write CTRL=0x0, hold 20 cycles with all events high, then write CTRL=0x1 → counters advance by exactly 1 (write cycle) during the disabled window.
- Write CTRL=0x3 in the same cycle as i_insn_vld=1 → INSN=0 afterwards, enable stays 1.
- Issue a read to 0x24, then a read with i_addr=0x05 (BASE_CHK=1), then assert reset in the cycle after a read issue → 0 with o_err=0; o_err=1 with o_rdata=0; no o_rvalid, all outputs 0.
